// File: rtl/grid_io_bank_if.sv
// Fabric-side bundle for grid_io_bank: configuration chain controls plus the
// per-pad data lanes to and from the fabric.
interface grid_io_bank_if #(
    parameter int NUM_PADS = 4
);
    logic                ccff_head;
    logic                ccff_en;
    logic                ccff_load;
    logic                ccff_tail;
    logic                cfg_full;
    logic [NUM_PADS-1:0] pin_outpad;
    logic [NUM_PADS-1:0] pin_inpad;

    modport master (
        output ccff_head,
        output ccff_en,
        output ccff_load,
        output pin_outpad,
        input  ccff_tail,
        input  cfg_full,
        input  pin_inpad
    );

    modport slave (
        input  ccff_head,
        input  ccff_en,
        input  ccff_load,
        input  pin_outpad,
        output ccff_tail,
        output cfg_full,
        output pin_inpad
    );
endinterface

// File: rtl/grid_io_bank.sv
// Multi-pad perimeter I/O tile: a shift-chain shadow configuration, committed
// on ccff_load, controls direction, registering and inversion of every pad.
module grid_io_bank #(
    parameter int NUM_PADS = 4,
    parameter int CFG_W    = 4
) (
    input  logic                prog_clk,
    input  logic                prog_reset,
    grid_io_bank_if.slave       bus,
    inout  wire  [NUM_PADS-1:0] gfpga_pad_GPIO_PAD
);
    localparam int CHAIN_LEN = NUM_PADS * CFG_W;
    localparam int CNT_W     = $clog2(CHAIN_LEN + 1);

    logic [CHAIN_LEN-1:0] sreg;
    logic [CHAIN_LEN-1:0] acfg;
    logic [CNT_W-1:0]     cnt;
    logic                 cnt_sat;

    logic [NUM_PADS-1:0] dir_v;
    logic [NUM_PADS-1:0] oreg_v;
    logic [NUM_PADS-1:0] ireg_v;
    logic [NUM_PADS-1:0] inv_v;
    logic [NUM_PADS-1:0] o_int;
    logic [NUM_PADS-1:0] o_drv;
    logic [NUM_PADS-1:0] i_int;
    logic [NUM_PADS-1:0] oq;
    logic [NUM_PADS-1:0] iq;

    assign cnt_sat = (cnt == CNT_W'(CHAIN_LEN));

    // Commit samples sreg before the same-edge shift, so acfg gets the pre-shift image.
    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            sreg <= '0;
            acfg <= '0;
            cnt  <= '0;
        end else begin
            if (bus.ccff_en) begin
                sreg <= {sreg[CHAIN_LEN-2:0], bus.ccff_head};
            end
            if (bus.ccff_load) begin
                acfg <= sreg;
                cnt  <= bus.ccff_en ? CNT_W'(1) : '0;
            end else if (bus.ccff_en && !cnt_sat) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign bus.ccff_tail = sreg[CHAIN_LEN-1];
    assign bus.cfg_full  = cnt_sat;

    always_comb begin
        dir_v  = '0;
        oreg_v = '0;
        ireg_v = '0;
        inv_v  = '0;
        for (int p = 0; p < NUM_PADS; p++) begin
            dir_v[p]  = acfg[CFG_W*p + 0];
            oreg_v[p] = acfg[CFG_W*p + 1];
            ireg_v[p] = acfg[CFG_W*p + 2];
            inv_v[p]  = acfg[CFG_W*p + 3];
        end
    end

    assign o_int = bus.pin_outpad ^ inv_v;
    assign o_drv = (oreg_v & oq) | (~oreg_v & o_int);
    assign i_int = gfpga_pad_GPIO_PAD ^ inv_v;
    assign bus.pin_inpad = (ireg_v & iq) | (~ireg_v & i_int);

    // Path registers run every cycle so enabling registering never exposes stale data.
    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            oq <= '0;
            iq <= '0;
        end else begin
            oq <= o_int;
            iq <= i_int;
        end
    end

    for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
        assign gfpga_pad_GPIO_PAD[p] = dir_v[p] ? o_drv[p] : 1'bz;
    end
endmodule
